// File: rtl/seg7_scan_display_pkg.sv
// Shared constants and hex-digit segment table for the 4-digit scanned display.
// Segment encoding is gfedcba (bit6..bit0), active-high in the table.
package seg7_scan_display_pkg;

    localparam int          NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex.sv
// Nibble to active-low 7-segment pattern; purely combinational.
// No state, no handshake.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = ~hex_seg(i_nib);

endmodule

// File: rtl/seg7_scan_display.sv
// Captures a 16-bit value and PC byte, scans four hex digits with a prescaled counter.
// All display outputs are registered: one clk behind the internal scan/capture state.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CHG_HOLD    = 25000000,
    parameter int BLANK_LZ    = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        capture_en,
    input  logic [15:0] data_in,
    input  logic [7:0]  pc_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic [7:0]  led
);

    localparam int PRE_W = (REFRESH_DIV < 2) ? 1 : $clog2(REFRESH_DIV);
    localparam int CHG_W = (CHG_HOLD < 1) ? 1 : $clog2(CHG_HOLD + 1);
    localparam int DIG_W = $clog2(NUM_DIGITS);

    logic [PRE_W-1:0] r_presc;
    logic [DIG_W-1:0] r_digit;
    logic [15:0]      r_data_q;
    logic [7:0]       r_led;
    logic [CHG_W-1:0] r_chg_cnt;
    logic [6:0]       r_seg_n;
    logic             r_dp_n;
    logic [3:0]       r_an_n;

    logic             w_presc_tc;
    logic             w_data_chg;
    logic             w_blank;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg_n;

    assign w_presc_tc = (r_presc == PRE_W'(REFRESH_DIV - 1));
    assign w_data_chg = capture_en && (data_in != r_data_q);
    assign w_nib      = r_data_q[{r_digit, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .i_nib   (w_nib),
        .o_seg_n (w_seg_n)
    );

    // Leading-zero blanking: a digit goes dark when it and everything above it is zero.
    always_comb begin
        w_blank = 1'b0;
        if (BLANK_LZ != 0) begin
            case (r_digit)
                2'd1:    w_blank = (r_data_q[15:4]  == 12'h000);
                2'd2:    w_blank = (r_data_q[15:8]  == 8'h00);
                2'd3:    w_blank = (r_data_q[15:12] == 4'h0);
                default: w_blank = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_digit   <= '0;
            r_data_q  <= '0;
            r_led     <= '0;
            r_chg_cnt <= '0;
            r_seg_n   <= SEG_BLANK;
            r_an_n    <= 4'hF;
            r_dp_n    <= 1'b1;
        end else begin
            r_presc <= w_presc_tc ? '0 : r_presc + 1'b1;
            if (w_presc_tc) begin
                r_digit <= r_digit + 1'b1;
            end

            if (capture_en) begin
                r_data_q <= data_in;
                r_led    <= pc_in;
            end

            // Reload on every genuine value change; otherwise bleed down to zero.
            if (w_data_chg) begin
                r_chg_cnt <= CHG_W'(CHG_HOLD);
            end else if (r_chg_cnt != '0) begin
                r_chg_cnt <= r_chg_cnt - 1'b1;
            end

            if (w_blank) begin
                r_seg_n <= SEG_BLANK;
                r_an_n  <= 4'hF;
                r_dp_n  <= 1'b1;
            end else begin
                r_seg_n <= w_seg_n;
                r_an_n  <= ~(4'b0001 << r_digit);
                r_dp_n  <= !((r_digit == '0) && (r_chg_cnt != '0));
            end
        end
    end

    assign seg_n = r_seg_n;
    assign dp_n  = r_dp_n;
    assign an_n  = r_an_n;
    assign led   = r_led;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench: two instances (no blanking / leading-zero blanking) share one stimulus.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        capture_en;
    logic [15:0] data_in;
    logic [7:0]  pc_in;
    logic [6:0]  seg_n,   seg_n_b;
    logic        dp_n,    dp_n_b;
    logic [3:0]  an_n,    an_n_b;
    logic [7:0]  led,     led_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(.REFRESH_DIV(4), .CHG_HOLD(6), .BLANK_LZ(0)) dut (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .data_in(data_in),
        .pc_in(pc_in), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .led(led)
    );

    seg7_scan_display #(.REFRESH_DIV(4), .CHG_HOLD(6), .BLANK_LZ(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .data_in(data_in),
        .pc_in(pc_in), .seg_n(seg_n_b), .dp_n(dp_n_b), .an_n(an_n_b), .led(led_b)
    );

    // One record per 4-clk digit slot. cap: 0 none, 1 pulse on first edge, 2 held all slot.
    typedef struct {
        logic [1:0]  cap;
        logic [15:0] din;
        logic [7:0]  pc;
        logic [3:0]  an;
        logic [6:0]  seg0;
        logic [6:0]  seg;
        logic [3:0]  anb0;
        logic [6:0]  segb0;
        logic [3:0]  anb;
        logic [6:0]  segb;
        logic [3:0]  dpm;
        logic [7:0]  led;
    } slot_t;

    slot_t tbl [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [1:0] cap, input logic [15:0] din,
                            input logic [7:0] pc, input logic [3:0] an, input logic [6:0] seg0,
                            input logic [6:0] seg, input logic [3:0] anb0, input logic [6:0] segb0,
                            input logic [3:0] anb, input logic [6:0] segb, input logic [3:0] dpm,
                            input logic [7:0] ledv);
        tbl[i] = '{cap, din, pc, an, seg0, seg, anb0, segb0, anb, segb, dpm, ledv};
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg_n"}, 16'(seg_n), 16'h7F);
        chk({tag, " an_n"},  16'(an_n),  16'hF);
        chk({tag, " dp_n"},  16'(dp_n),  16'h1);
        chk({tag, " led"},   16'(led),   16'h00);
        chk({tag, " seg_n_b"}, 16'(seg_n_b), 16'h7F);
        chk({tag, " an_n_b"},  16'(an_n_b),  16'hF);
    endtask

    initial begin
        logic [6:0] hold_seg [4];
        logic [3:0] exp_an;
        int d;

        //        i  cap din       pc     an    seg0   seg    anb0  segb0  anb   segb   dpm      led
        set_slot( 0, 0, 16'h0000, 8'h00, 4'hE, 7'h40, 7'h40, 4'hE, 7'h40, 4'hE, 7'h40, 4'b1111, 8'h00);
        set_slot( 1, 0, 16'h0000, 8'h00, 4'hD, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h00);
        set_slot( 2, 0, 16'h0000, 8'h00, 4'hB, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h00);
        set_slot( 3, 0, 16'h0000, 8'h00, 4'h7, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h00);
        set_slot( 4, 1, 16'h12AF, 8'h15, 4'hE, 7'h40, 7'h0E, 4'hE, 7'h40, 4'hE, 7'h0E, 4'b0001, 8'h15);
        set_slot( 5, 0, 16'h12AF, 8'h15, 4'hD, 7'h08, 7'h08, 4'hD, 7'h08, 4'hD, 7'h08, 4'b1111, 8'h15);
        set_slot( 6, 0, 16'h12AF, 8'h15, 4'hB, 7'h24, 7'h24, 4'hB, 7'h24, 4'hB, 7'h24, 4'b1111, 8'h15);
        set_slot( 7, 0, 16'h12AF, 8'h15, 4'h7, 7'h79, 7'h79, 4'h7, 7'h79, 4'h7, 7'h79, 4'b1111, 8'h15);
        set_slot( 8, 2, 16'h3C07, 8'hA5, 4'hE, 7'h0E, 7'h78, 4'hE, 7'h0E, 4'hE, 7'h78, 4'b0001, 8'hA5);
        set_slot( 9, 2, 16'h3C07, 8'hA5, 4'hD, 7'h40, 7'h40, 4'hD, 7'h40, 4'hD, 7'h40, 4'b1111, 8'hA5);
        set_slot(10, 2, 16'h3C07, 8'hA5, 4'hB, 7'h46, 7'h46, 4'hB, 7'h46, 4'hB, 7'h46, 4'b1111, 8'hA5);
        set_slot(11, 2, 16'h3C07, 8'hA5, 4'h7, 7'h30, 7'h30, 4'h7, 7'h30, 4'h7, 7'h30, 4'b1111, 8'hA5);
        set_slot(12, 2, 16'h3C07, 8'hA5, 4'hE, 7'h78, 7'h78, 4'hE, 7'h78, 4'hE, 7'h78, 4'b1111, 8'hA5);
        set_slot(13, 1, 16'h0005, 8'h3C, 4'hD, 7'h40, 7'h40, 4'hD, 7'h40, 4'hF, 7'h7F, 4'b1111, 8'h3C);
        set_slot(14, 0, 16'h0005, 8'h3C, 4'hB, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h3C);
        set_slot(15, 0, 16'h0005, 8'h3C, 4'h7, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h3C);
        set_slot(16, 0, 16'h0005, 8'h3C, 4'hE, 7'h12, 7'h12, 4'hE, 7'h12, 4'hE, 7'h12, 4'b1111, 8'h3C);
        set_slot(17, 1, 16'h0100, 8'h81, 4'hD, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hD, 7'h40, 4'b1111, 8'h81);
        set_slot(18, 0, 16'h0100, 8'h81, 4'hB, 7'h79, 7'h79, 4'hB, 7'h79, 4'hB, 7'h79, 4'b1111, 8'h81);
        set_slot(19, 0, 16'h0100, 8'h81, 4'h7, 7'h40, 7'h40, 4'hF, 7'h7F, 4'hF, 7'h7F, 4'b1111, 8'h81);
        set_slot(20, 0, 16'h0100, 8'h81, 4'hE, 7'h40, 7'h40, 4'hE, 7'h40, 4'hE, 7'h40, 4'b1111, 8'h81);

        reset_n    = 1'b0;
        capture_en = 1'b0;
        data_in    = 16'h0000;
        pc_in      = 8'h00;
        repeat (3) tick();
        chk_reset("por");
        reset_n = 1'b1;

        for (int s = 0; s < 21; s++) begin
            for (int k = 0; k < 4; k++) begin
                capture_en = (tbl[s].cap == 2'd2) || (tbl[s].cap == 2'd1 && k == 0);
                data_in    = tbl[s].din;
                pc_in      = tbl[s].pc;
                tick();
                chk($sformatf("s%0d.%0d an_n", s, k), 16'(an_n), 16'(tbl[s].an));
                chk($sformatf("s%0d.%0d seg_n", s, k), 16'(seg_n),
                    16'((k == 0) ? tbl[s].seg0 : tbl[s].seg));
                chk($sformatf("s%0d.%0d dp_n", s, k), 16'(dp_n), 16'(tbl[s].dpm[k]));
                chk($sformatf("s%0d.%0d led", s, k), 16'(led), 16'(tbl[s].led));
                chk($sformatf("s%0d.%0d an_n_b", s, k), 16'(an_n_b),
                    16'((k == 0) ? tbl[s].anb0 : tbl[s].anb));
                chk($sformatf("s%0d.%0d seg_n_b", s, k), 16'(seg_n_b),
                    16'((k == 0) ? tbl[s].segb0 : tbl[s].segb));
                chk($sformatf("s%0d.%0d dp_n_b", s, k), 16'(dp_n_b), 16'(tbl[s].dpm[k]));
            end
        end

        // Reset landing mid-scan: digit 2 showing, change counter at 3.
        capture_en = 1'b0;
        repeat (2) tick();
        capture_en = 1'b1; data_in = 16'hBEEF; pc_in = 8'h77;
        tick();
        capture_en = 1'b0;
        repeat (3) tick();
        chk("midscan an_n", 16'(an_n), 16'hB);
        chk("midscan seg_n", 16'(seg_n), 16'h06);
        reset_n = 1'b0;
        tick();
        chk_reset("midscan reset");
        reset_n = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            tick();
            chk($sformatf("restart f%0d an_n", f), 16'(an_n), (f <= 4) ? 16'hE : 16'hD);
            chk($sformatf("restart f%0d seg_n", f), 16'(seg_n), 16'h40);
            chk($sformatf("restart f%0d dp_n", f), 16'(dp_n), 16'h1);
        end

        // Capture once, then hold with capture_en=0 while inputs churn.
        capture_en = 1'b1; data_in = 16'h5A3C; pc_in = 8'h99;
        tick();
        capture_en = 1'b0;
        repeat (7) tick();
        hold_seg[0] = 7'h46; hold_seg[1] = 7'h30; hold_seg[2] = 7'h08; hold_seg[3] = 7'h12;
        for (int f = 14; f < 114; f++) begin
            data_in = 16'($urandom);
            pc_in   = 8'($urandom);
            tick();
            d      = ((f - 1) / 4) % 4;
            exp_an = ~(4'b0001 << d);
            chk($sformatf("hold f%0d an_n", f), 16'(an_n), 16'(exp_an));
            chk($sformatf("hold f%0d seg_n", f), 16'(seg_n), 16'(hold_seg[d]));
            chk($sformatf("hold f%0d dp_n", f), 16'(dp_n), 16'h1);
            chk($sformatf("hold f%0d led", f), 16'(led), 16'h99);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
